mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter AWIDTH, default 32, address width of both requester ports and the memory port.
REQ-002 The block SHALL have parameter DWIDTH, default 32, data width of all data buses.
REQ-003 The block SHALL have parameter PRIOMODE, default 0, arbitration mode: 0 = round-robin, 1 = data port always wins.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port clr, input, 1, reset, asynchronous, active-low.
REQ-006 The block SHALL have port i_req, input, 1, instruction-fetch read request.
REQ-007 The block SHALL have port i_addr, input, AWIDTH, fetch address; valid while i_req=1.
REQ-008 The block SHALL have port i_gnt, output, 1, fetch request accepted this cycle.
REQ-009 The block SHALL have port i_rvalid, output, 1, fetch read data valid.
REQ-010 The block SHALL have port i_rdata, output, DWIDTH, fetch read data.
REQ-011 The block SHALL have port d_req, input, 1, data-port request.
REQ-012 The block SHALL have port d_wr, input, 1, data-port access type: 1 = write, 0 = read.
REQ-013 The block SHALL have port d_addr, input, AWIDTH, data-port address.
REQ-014 The block SHALL have port d_wdata, input, DWIDTH, data-port write data.
REQ-015 The block SHALL have port d_gnt, output, 1, data request accepted this cycle.
REQ-016 The block SHALL have port d_rvalid, output, 1, data read data valid.
REQ-017 The block SHALL have port d_rdata, output, DWIDTH, data read data.
REQ-018 The block SHALL have memory-side ports m_address (output, AWIDTH), m_din (output, DWIDTH), m_dout (input, DWIDTH), m_rd, m_wr and m_cs (outputs, 1 each), which connect to one shared sram whose dout is registered one clock after the address is presented.

Function
REQ-019 A request SHALL be accepted in the cycle it is asserted: x_gnt is combinational from x_req, the other port's request and the priority pointer, and x_gnt=1 only if x_req=1.
REQ-020 At most one of i_gnt and d_gnt SHALL be 1 in any cycle.
REQ-021 When only one port requests, that port SHALL be granted.
REQ-022 When both ports request, the port named by the 1-bit priority pointer SHALL be granted; with PRIOMODE=0 the pointer then moves to the other port; with PRIOMODE=1 d is always granted and the pointer is unused.
REQ-023 The pointer SHALL change only on a cycle with a grant under contention; uncontested grants leave it unchanged.
REQ-024 On the edge ending a grant cycle, the block SHALL latch the stage-1 registers: valid=1, owner, address, wr, wdata. The address is i_addr for the fetch port or d_addr for the data port; wr is 0 for the fetch port or d_wr for the data port.
REQ-025 With no grant, stage-1 valid SHALL load 0.
REQ-026 In the cycle after a grant, m_cs=stage-1 valid, m_rd=valid&~wr, m_wr=valid&wr, m_address=latched address and m_din=latched wdata; when valid=0, all three strobes are 0.
REQ-027 For a read, the owner's x_rvalid SHALL be 1 exactly one cycle after the memory access cycle (grant+2), with x_rdata=m_dout in that cycle; writes produce no rvalid.
REQ-028 The non-owner rvalid SHALL be 0; x_rdata is don't-care when x_rvalid=0.
REQ-029 The block SHALL accept one new request every cycle (fully pipelined, no back-pressure beyond arbitration loss); a requester holding x_req=1 after x_gnt issues a new access.
REQ-030 Memory accesses SHALL occur strictly in grant order, so a d write granted before an i read of the same address returns the written data.
REQ-031 A losing requester SHALL keep x_req and payload stable until granted; the block keeps no per-port queue.

Reset
REQ-032 While clr=0, the block SHALL hold stage-1 valid=0, the read-return register=0, the pointer pointing to d, m_cs=m_rd=m_wr=0, i_rvalid=d_rvalid=0 and i_gnt=d_gnt=0, regardless of requests.
REQ-033 Reset asserted mid-operation SHALL discard the latched access and any pending rvalid immediately, with no memory strobe after clr falls.
REQ-034 After clr rises, the first cycle SHALL arbitrate normally.

Verification
REQ-035 Scenario: i_req=1, i_addr=0x10, d_req=0 at cycle 0 -> i_gnt=1 in cycle 0; m_cs=m_rd=1 and m_address=0x10 in cycle 1; i_rvalid=1 with i_rdata=mem[0x10] in cycle 2.
REQ-036 Scenario: PRIOMODE=0, both requesters held for 4 cycles after reset -> grants d,i,d,i; exactly one gnt per cycle.
REQ-037 Scenario: PRIOMODE=1, both requesters held for 3 cycles -> d_gnt=1 in all 3 cycles and i_gnt=0 throughout.
REQ-038 Scenario: d write 0xDEADBEEF to 0x40, granted at cycle 0; i read of 0x40 granted at cycle 1 -> m_wr=1 in cycle 1, d_rvalid never 1, i_rvalid=1 with i_rdata=0xDEADBEEF in cycle 3.
REQ-039 Scenario: d read granted at cycle 0, clr=0 during cycle 1 -> m_cs=0 from clr fall, d_rvalid stays 0, and the pointer is back at d.
REQ-040 Scenario: i_req held high for 3 cycles with addresses 0,4,8 -> 3 consecutive i_gnt, then i_rvalid in cycles 2,3,4 with data from addresses 0,4,8 in order.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter in front of one registered-output sram.
// Combinational grant, one-cycle request latch, read data returned at grant+2.
module mem_arbiter #(
    parameter int unsigned AWIDTH   = 32,
    parameter int unsigned DWIDTH   = 32,
    parameter int unsigned PRIOMODE = 0
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              i_req,
    input  logic [AWIDTH-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DWIDTH-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [AWIDTH-1:0] d_addr,
    input  logic [DWIDTH-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DWIDTH-1:0] d_rdata,
    output logic [AWIDTH-1:0] m_address,
    output logic [DWIDTH-1:0] m_din,
    input  logic [DWIDTH-1:0] m_dout,
    output logic              m_rd,
    output logic              m_wr,
    output logic              m_cs
);

    logic              prio_d;     // 1: data port wins the next contention
    logic              contend;
    logic              s1_valid;
    logic              s1_owner;   // 1: data port
    logic              s1_wr;
    logic [AWIDTH-1:0] s1_addr;
    logic [DWIDTH-1:0] s1_wdata;
    logic              s2_valid;
    logic              s2_owner;

    // Grant selection; held off entirely while in reset
    always_comb begin
        contend = i_req & d_req;
        i_gnt   = 1'b0;
        d_gnt   = 1'b0;
        if (clr) begin
            if (PRIOMODE == 1) begin
                d_gnt = d_req;
                i_gnt = i_req & ~d_req;
            end else if (contend) begin
                d_gnt = prio_d;
                i_gnt = ~prio_d;
            end else begin
                i_gnt = i_req;
                d_gnt = d_req;
            end
        end
    end

    // Round-robin pointer flips only after a contended grant
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            prio_d <= 1'b1;
        end else if ((PRIOMODE == 0) && contend && (i_gnt | d_gnt)) begin
            prio_d <= ~prio_d;
        end
    end

    // Stage 1: the granted access, presented to the sram next cycle
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            s1_valid <= 1'b0;
            s1_owner <= 1'b0;
            s1_wr    <= 1'b0;
            s1_addr  <= '0;
            s1_wdata <= '0;
        end else begin
            s1_valid <= i_gnt | d_gnt;
            s1_owner <= d_gnt;
            s1_wr    <= d_gnt & d_wr;
            s1_addr  <= d_gnt ? d_addr : i_addr;
            s1_wdata <= d_gnt ? d_wdata : '0;
        end
    end

    // Stage 2: read return tracking, aligned with the sram's registered dout
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            s2_valid <= 1'b0;
            s2_owner <= 1'b0;
        end else begin
            s2_valid <= s1_valid & ~s1_wr;
            s2_owner <= s1_owner;
        end
    end

    assign m_cs      = s1_valid;
    assign m_rd      = s1_valid & ~s1_wr;
    assign m_wr      = s1_valid & s1_wr;
    assign m_address = s1_addr;
    assign m_din     = s1_wdata;

    assign i_rvalid  = s2_valid & ~s2_owner;
    assign d_rvalid  = s2_valid & s2_owner;
    assign i_rdata   = m_dout;
    assign d_rdata   = m_dout;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: round-robin instance with an sram model,
// plus a fixed-priority instance sharing the same stimulus.
module tb_mem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          clr = 1'b0;
    logic          i_req = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic          d_req = 1'b0;
    logic          d_wr = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;

    logic          i_gnt, i_rvalid, d_gnt, d_rvalid, m_rd, m_wr, m_cs;
    logic [DW-1:0] i_rdata, d_rdata, m_din, m_dout;
    logic [AW-1:0] m_address;

    logic          p_i_gnt, p_i_rvalid, p_d_gnt, p_d_rvalid, p_m_rd, p_m_wr, p_m_cs;
    logic [DW-1:0] p_i_rdata, p_d_rdata, p_m_din;
    logic [DW-1:0] p_m_dout = '0;
    logic [AW-1:0] p_m_address;

    logic [DW-1:0] mem [256];

    int asserts = 0;
    int fails   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .PRIOMODE(0)) dut (
        .clk(clk), .clr(clr),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_address(m_address), .m_din(m_din), .m_dout(m_dout),
        .m_rd(m_rd), .m_wr(m_wr), .m_cs(m_cs)
    );

    mem_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .PRIOMODE(1)) dut_prio (
        .clk(clk), .clr(clr),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(p_i_gnt), .i_rvalid(p_i_rvalid), .i_rdata(p_i_rdata),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(p_d_gnt), .d_rvalid(p_d_rvalid), .d_rdata(p_d_rdata),
        .m_address(p_m_address), .m_din(p_m_din), .m_dout(p_m_dout),
        .m_rd(p_m_rd), .m_wr(p_m_wr), .m_cs(p_m_cs)
    );

    // Sram with dout registered one clock after the address
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 | 32'(i);
    end
    always @(posedge clk) begin
        if (m_cs) begin
            if (m_wr) mem[m_address[7:0]] <= m_din;
            else      m_dout <= mem[m_address[7:0]];
        end
    end

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        clr = 1'b0;
        next_cycle();
        next_cycle();
        clr = 1'b1;
    endtask

    task automatic test_reset;
        i_req = 1'b1; d_req = 1'b1; i_addr = 32'h10; d_addr = 32'h20;
        next_cycle();
        @(negedge clk);
        asserts++;
        if ({i_gnt, d_gnt, p_i_gnt, p_d_gnt} !== 4'b0000) begin
            fails++; $display("FAIL reset_gnt: got %b, expected 0000", {i_gnt, d_gnt, p_i_gnt, p_d_gnt});
        end
        asserts++;
        if ({m_cs, m_rd, m_wr, i_rvalid, d_rvalid} !== 5'b00000) begin
            fails++; $display("FAIL reset_strobes: got %b, expected 00000", {m_cs, m_rd, m_wr, i_rvalid, d_rvalid});
        end
        i_req = 1'b0; d_req = 1'b0;
        next_cycle();
    endtask

    task automatic test_single_read;
        do_reset();
        i_req = 1'b1; i_addr = 32'h10;
        @(negedge clk);
        asserts++;
        if ({i_gnt, d_gnt} !== 2'b10) begin
            fails++; $display("FAIL single_gnt: got %b, expected 10", {i_gnt, d_gnt});
        end
        next_cycle();
        i_req = 1'b0;
        @(negedge clk);
        asserts++;
        if ({m_cs, m_rd, m_wr} !== 3'b110 || m_address !== 32'h10) begin
            fails++; $display("FAIL single_access: cs/rd/wr %b addr %h, expected 110 addr 00000010", {m_cs, m_rd, m_wr}, m_address);
        end
        next_cycle();
        @(negedge clk);
        asserts++;
        if ({i_rvalid, d_rvalid} !== 2'b10 || i_rdata !== 32'hA000_0010) begin
            fails++; $display("FAIL single_rdata: rvalid %b data %h, expected 10 data a0000010", {i_rvalid, d_rvalid}, i_rdata);
        end
        next_cycle();
    endtask

    task automatic test_round_robin;
        logic [3:0] exp_d;
        exp_d = 4'b0101;    // bit k: data port granted in cycle k
        do_reset();
        i_req = 1'b1; i_addr = 32'h20; d_req = 1'b1; d_addr = 32'h30; d_wr = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (k == 4) begin i_req = 1'b0; d_req = 1'b0; end
            @(negedge clk);
            if (k < 4) begin
                asserts++;
                if ({i_gnt, d_gnt} !== {~exp_d[k], exp_d[k]}) begin
                    fails++; $display("FAIL rr_gnt cycle %0d: got %b, expected %b", k, {i_gnt, d_gnt}, {~exp_d[k], exp_d[k]});
                end
            end
            if (k >= 2) begin
                asserts++;
                if (exp_d[k-2]) begin
                    if ({i_rvalid, d_rvalid} !== 2'b01 || d_rdata !== 32'hA000_0030) begin
                        fails++; $display("FAIL rr_return cycle %0d: rvalid %b d_rdata %h, expected 01 a0000030", k, {i_rvalid, d_rvalid}, d_rdata);
                    end
                end else begin
                    if ({i_rvalid, d_rvalid} !== 2'b10 || i_rdata !== 32'hA000_0020) begin
                        fails++; $display("FAIL rr_return cycle %0d: rvalid %b i_rdata %h, expected 10 a0000020", k, {i_rvalid, d_rvalid}, i_rdata);
                    end
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_prio_fixed;
        do_reset();
        i_req = 1'b1; i_addr = 32'h20; d_req = 1'b1; d_addr = 32'h30; d_wr = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            asserts++;
            if ({p_i_gnt, p_d_gnt} !== 2'b01) begin
                fails++; $display("FAIL prio_gnt cycle %0d: got %b, expected 01", k, {p_i_gnt, p_d_gnt});
            end
            next_cycle();
        end
        i_req = 1'b0; d_req = 1'b0;
        next_cycle();
        next_cycle();
    endtask

    task automatic test_write_then_read;
        do_reset();
        d_req = 1'b1; d_wr = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        asserts++;
        if ({i_gnt, d_gnt} !== 2'b01) begin
            fails++; $display("FAIL wr_gnt: got %b, expected 01", {i_gnt, d_gnt});
        end
        next_cycle();
        d_req = 1'b0; d_wr = 1'b0; i_req = 1'b1; i_addr = 32'h40;
        @(negedge clk);
        asserts++;
        if ({i_gnt, d_gnt} !== 2'b10 || {m_cs, m_rd, m_wr} !== 3'b101
            || m_address !== 32'h40 || m_din !== 32'hDEAD_BEEF) begin
            fails++; $display("FAIL wr_access: gnt %b cs/rd/wr %b addr %h din %h, expected 10 101 00000040 deadbeef",
                              {i_gnt, d_gnt}, {m_cs, m_rd, m_wr}, m_address, m_din);
        end
        next_cycle();
        i_req = 1'b0;
        @(negedge clk);
        asserts++;
        if (d_rvalid !== 1'b0 || {m_cs, m_rd, m_wr} !== 3'b110) begin
            fails++; $display("FAIL wr_no_rvalid: d_rvalid %b cs/rd/wr %b, expected 0 110", d_rvalid, {m_cs, m_rd, m_wr});
        end
        next_cycle();
        @(negedge clk);
        asserts++;
        if ({i_rvalid, d_rvalid} !== 2'b10 || i_rdata !== 32'hDEAD_BEEF) begin
            fails++; $display("FAIL raw_rdata: rvalid %b data %h, expected 10 deadbeef", {i_rvalid, d_rvalid}, i_rdata);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid;
        do_reset();
        i_req = 1'b1; i_addr = 32'h20; d_req = 1'b1; d_addr = 32'h30; d_wr = 1'b0;
        next_cycle();       // contended d grant moves pointer to i
        i_req = 1'b0;
        @(negedge clk);
        asserts++;
        if ({i_gnt, d_gnt} !== 2'b01) begin
            fails++; $display("FAIL mid_gnt: got %b, expected 01", {i_gnt, d_gnt});
        end
        next_cycle();
        d_req = 1'b0;
        #2;
        asserts++;
        if (m_cs !== 1'b1 || d_rvalid !== 1'b1) begin
            fails++; $display("FAIL mid_before: m_cs %b d_rvalid %b, expected 1 1", m_cs, d_rvalid);
        end
        clr = 1'b0;
        #1;
        asserts++;
        if ({m_cs, m_rd, m_wr, d_rvalid, i_rvalid} !== 5'b00000) begin
            fails++; $display("FAIL mid_flush: got %b, expected 00000", {m_cs, m_rd, m_wr, d_rvalid, i_rvalid});
        end
        next_cycle();
        @(negedge clk);
        asserts++;
        if ({m_cs, d_rvalid, i_rvalid} !== 3'b000) begin
            fails++; $display("FAIL mid_hold: got %b, expected 000", {m_cs, d_rvalid, i_rvalid});
        end
        next_cycle();
        clr = 1'b1; i_req = 1'b1; d_req = 1'b1;
        @(negedge clk);
        asserts++;
        if ({i_gnt, d_gnt} !== 2'b01) begin
            fails++; $display("FAIL mid_pointer: got %b, expected 01", {i_gnt, d_gnt});
        end
        next_cycle();
        i_req = 1'b0; d_req = 1'b0;
        next_cycle();
        next_cycle();
    endtask

    task automatic test_back_to_back;
        logic [AW-1:0] addrs [3];
        logic [DW-1:0] datas [3];
        addrs = '{32'h0, 32'h4, 32'h8};
        datas = '{32'hA000_0000, 32'hA000_0004, 32'hA000_0008};
        do_reset();
        for (int k = 0; k < 5; k++) begin
            i_req  = (k < 3);
            i_addr = (k < 3) ? addrs[k] : 32'h0;
            @(negedge clk);
            if (k < 3) begin
                asserts++;
                if (i_gnt !== 1'b1) begin
                    fails++; $display("FAIL b2b_gnt cycle %0d: got %b, expected 1", k, i_gnt);
                end
            end
            if (k >= 1 && k <= 3) begin
                asserts++;
                if (m_rd !== 1'b1 || m_address !== addrs[k-1]) begin
                    fails++; $display("FAIL b2b_addr cycle %0d: rd %b addr %h, expected 1 %h", k, m_rd, m_address, addrs[k-1]);
                end
            end
            if (k >= 2) begin
                asserts++;
                if (i_rvalid !== 1'b1 || i_rdata !== datas[k-2]) begin
                    fails++; $display("FAIL b2b_rdata cycle %0d: rvalid %b data %h, expected 1 %h", k, i_rvalid, i_rdata, datas[k-2]);
                end
            end
            next_cycle();
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_prio_fixed();
        test_write_then_read();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
